// File: rtl/rv_sdram_bridge_if.sv
// Bus bundle between the RISC-V native memory port, the bridge and the
// sdram_nes RV toggle port. The bridge uses the slave view; the CPU and
// controller side uses the master view.
interface rv_sdram_bridge_if;
   // CPU native memory bus
   logic        i_mem_valid;
   logic [22:0] i_mem_addr;
   logic [31:0] i_mem_wdata;
   logic [3:0]  i_mem_wstrb;
   logic        o_mem_ready;
   logic [31:0] o_mem_rdata;
   logic        o_timeout;
   // SDRAM controller RV toggle port
   logic [22:0] o_rv_addr;
   logic        o_rv_word;
   logic [31:0] o_rv_wdata;
   logic [1:0]  o_rv_ds;
   logic [3:0]  o_rv_wstrb;
   logic        o_rv_req;
   logic        i_rv_req_ack;
   logic [15:0] i_rv_dout;

   modport slave (
      input  i_mem_valid, i_mem_addr, i_mem_wdata, i_mem_wstrb,
      input  i_rv_req_ack, i_rv_dout,
      output o_mem_ready, o_mem_rdata, o_timeout,
      output o_rv_addr, o_rv_word, o_rv_wdata, o_rv_ds, o_rv_wstrb, o_rv_req
   );

   modport master (
      output i_mem_valid, i_mem_addr, i_mem_wdata, i_mem_wstrb,
      output i_rv_req_ack, i_rv_dout,
      input  o_mem_ready, o_mem_rdata, o_timeout,
      input  o_rv_addr, o_rv_word, o_rv_wdata, o_rv_ds, o_rv_wstrb, o_rv_req
   );
endinterface

// File: rtl/rv_sdram_bridge.sv
// 32-bit RISC-V memory bus to 16-bit toggle-handshake SDRAM port bridge.
// Each CPU access becomes one or two 16-bit halves (low first), with a
// per-half watchdog that aborts with all-ones data and a timeout pulse.
module rv_sdram_bridge #(
   parameter int TIMEOUT_CYCLES = 1023
) (
   input logic              i_clk,
   input logic              i_resetn,
   rv_sdram_bridge_if.slave bus
);
   localparam int               CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_t;

   state_t           state;
   logic [CNT_W-1:0] wd_cnt;
   logic             is_write;
   logic             acked;
   logic             expired;

   // Latched strobes decide read/write for the whole transaction; a half is
   // done once the ack toggle has caught up with our request toggle.
   assign is_write = |bus.o_rv_wstrb;
   assign acked    = (bus.i_rv_req_ack == bus.o_rv_req);
   assign expired  = (wd_cnt == CNT_LIMIT);

   // Transaction sequencer: accept, issue low/high halves, watchdog, respond.
   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         state           <= IDLE;
         wd_cnt          <= '0;
         bus.o_mem_ready <= 1'b0;
         bus.o_mem_rdata <= '0;
         bus.o_timeout   <= 1'b0;
         bus.o_rv_addr   <= '0;
         bus.o_rv_word   <= 1'b0;
         bus.o_rv_wdata  <= '0;
         bus.o_rv_ds     <= '0;
         bus.o_rv_wstrb  <= '0;
         bus.o_rv_req    <= 1'b0;
      end else begin
         bus.o_mem_ready <= 1'b0;
         bus.o_timeout   <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.o_rv_req != bus.i_rv_req_ack) begin
                  // Realign after an aborted half (or a late ack) before
                  // starting anything new.
                  bus.o_rv_req <= bus.i_rv_req_ack;
               end else if (bus.i_mem_valid && !bus.o_mem_ready) begin
                  bus.o_rv_addr  <= bus.i_mem_addr & ~23'd3;
                  bus.o_rv_wdata <= bus.i_mem_wdata;
                  bus.o_rv_wstrb <= bus.i_mem_wstrb;
                  bus.o_rv_req   <= ~bus.o_rv_req;
                  wd_cnt         <= '0;
                  if ((bus.i_mem_wstrb != 4'b0000) && (bus.i_mem_wstrb[1:0] == 2'b00)) begin
                     state       <= HI;
                     bus.o_rv_word <= 1'b1;
                     bus.o_rv_ds   <= bus.i_mem_wstrb[3:2];
                  end else begin
                     state       <= LO;
                     bus.o_rv_word <= 1'b0;
                     bus.o_rv_ds   <= (bus.i_mem_wstrb == 4'b0000) ? 2'b11 : bus.i_mem_wstrb[1:0];
                  end
               end
            end
            LO: begin
               if (acked) begin
                  if (!is_write) begin
                     bus.o_mem_rdata[15:0] <= bus.i_rv_dout;
                  end
                  if (is_write && (bus.o_rv_wstrb[3:2] == 2'b00)) begin
                     state           <= RESP;
                     bus.o_mem_ready <= 1'b1;
                  end else begin
                     state         <= HI;
                     bus.o_rv_req  <= ~bus.o_rv_req;
                     bus.o_rv_word <= 1'b1;
                     bus.o_rv_ds   <= is_write ? bus.o_rv_wstrb[3:2] : 2'b11;
                     wd_cnt        <= '0;
                  end
               end else if (expired) begin
                  state           <= RESP;
                  bus.o_mem_ready <= 1'b1;
                  bus.o_timeout   <= 1'b1;
                  bus.o_mem_rdata <= 32'hFFFF_FFFF;
               end else begin
                  wd_cnt <= wd_cnt + CNT_W'(1);
               end
            end
            HI: begin
               if (acked) begin
                  if (!is_write) begin
                     bus.o_mem_rdata[31:16] <= bus.i_rv_dout;
                  end
                  state           <= RESP;
                  bus.o_mem_ready <= 1'b1;
               end else if (expired) begin
                  state           <= RESP;
                  bus.o_mem_ready <= 1'b1;
                  bus.o_timeout   <= 1'b1;
                  bus.o_mem_rdata <= 32'hFFFF_FFFF;
               end else begin
                  wd_cnt <= wd_cnt + CNT_W'(1);
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_rv_sdram_bridge.sv
// Bench for rv_sdram_bridge: a toggle-port SDRAM model with configurable ack
// delay, a word-level reference memory, and scoreboards for the 16-bit halves
// and the CPU responses.
module tb_rv_sdram_bridge;
   localparam int TO = 16;

   logic clk = 1'b0;
   logic resetn = 1'b1;
   always #5 clk = ~clk;

   rv_sdram_bridge_if bus ();

   rv_sdram_bridge #(.TIMEOUT_CYCLES(TO)) dut (
      .i_clk   (clk),
      .i_resetn(resetn),
      .bus     (bus)
   );

   typedef struct {
      logic        req;
      logic        word;
      logic [1:0]  ds;
      logic [22:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } tog_t;

   typedef struct {
      logic [31:0] rdata;
      logic        tmo;
      logic        is_read;
   } resp_t;

   tog_t  exp_tog[$];
   resp_t exp_resp[$];

   int   n_tests = 0;
   int   n_fail = 0;
   bit   chk_tog = 1'b0;
   logic exp_req = 1'b0;
   int   ack_delay = 4;
   bit   dead = 1'b0;
   int   late_req_cnt = 0;

   logic [31:0] ref_mem [logic [20:0]];
   logic [15:0] cmem    [logic [21:0]];

   function automatic logic [15:0] dflt(logic [20:0] w, bit hi);
      return 16'(w * 21'h1B3) ^ (hi ? 16'hA5C3 : 16'h3C5A);
   endfunction

   function automatic logic [31:0] ref_read(logic [20:0] w);
      if (ref_mem.exists(w)) return ref_mem[w];
      return {dflt(w, 1'b1), dflt(w, 1'b0)};
   endfunction

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic finish_sim();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   endtask

   // SDRAM controller model: answers a pending toggle after ack_delay cycles.
   initial begin
      int          ccnt;
      int          late_done;
      logic [21:0] key;
      logic [15:0] val;
      ccnt = 0;
      late_done = 0;
      bus.i_rv_req_ack = 1'b0;
      bus.i_rv_dout = 16'h0;
      forever begin
         @(negedge clk);
         if (!resetn) begin
            bus.i_rv_req_ack = 1'b0;
            ccnt = 0;
         end else if (late_done != late_req_cnt) begin
            late_done = late_req_cnt;
            bus.i_rv_req_ack = ~bus.i_rv_req_ack;
         end else if (dead || (bus.o_rv_req == bus.i_rv_req_ack)) begin
            ccnt = 0;
         end else begin
            ccnt++;
            if (ccnt == ack_delay + 1) begin
               key = {bus.o_rv_addr[22:2], bus.o_rv_word};
               val = cmem.exists(key) ? cmem[key] : dflt(bus.o_rv_addr[22:2], bus.o_rv_word);
               if (bus.o_rv_wstrb != 4'b0000) begin
                  for (int b = 0; b < 2; b++)
                     if (bus.o_rv_ds[b]) val[b*8 +: 8] = bus.o_rv_wdata[(bus.o_rv_word ? 16 : 0) + b*8 +: 8];
                  cmem[key] = val;
               end else begin
                  bus.i_rv_dout = val;
               end
               bus.i_rv_req_ack = bus.o_rv_req;
               ccnt = 0;
            end
         end
      end
   end

   // Monitor: compares every request toggle and every ready pulse.
   initial begin
      logic  prev_req;
      bit    prev_ready;
      tog_t  t;
      resp_t r;
      prev_req = 1'b0;
      prev_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (bus.o_rv_req !== prev_req) begin
            prev_req = bus.o_rv_req;
            if (chk_tog) begin
               if (exp_tog.size() == 0) begin
                  check("unexpected_toggle", 64'(exp_tog.size()), 64'd1);
               end else begin
                  t = exp_tog.pop_front();
                  check("tog_req", bus.o_rv_req, t.req);
                  check("tog_word", bus.o_rv_word, t.word);
                  check("tog_ds", bus.o_rv_ds, t.ds);
                  check("tog_addr", bus.o_rv_addr, t.addr);
                  check("tog_wstrb", bus.o_rv_wstrb, t.wstrb);
                  if (t.wstrb != 4'b0000) check("tog_wdata", bus.o_rv_wdata, t.wdata);
               end
            end
         end
         if (bus.o_mem_ready === 1'b1) begin
            check("ready_width", prev_ready, 1'b0);
            if (exp_resp.size() == 0) begin
               check("unexpected_ready", 64'(exp_resp.size()), 64'd1);
            end else begin
               r = exp_resp.pop_front();
               check("timeout_flag", bus.o_timeout, r.tmo);
               if (r.is_read || r.tmo) check("rdata", bus.o_mem_rdata, r.rdata);
            end
         end
         prev_ready = (bus.o_mem_ready === 1'b1);
      end
   end

   task automatic push_tog(logic word, logic [1:0] ds, logic [22:0] a, logic [31:0] wd, logic [3:0] ws);
      tog_t t;
      exp_req = ~exp_req;
      t.req = exp_req; t.word = word; t.ds = ds;
      t.addr = a & ~23'd3; t.wdata = wd; t.wstrb = ws;
      exp_tog.push_back(t);
   endtask

   // Drive one CPU access starting at a negedge; returns at the negedge where
   // ready is seen. lat_off < 0 skips the latency check.
   task automatic issue(logic [22:0] a, logic [31:0] wd, logic [3:0] ws, int A, bit tmo, int lat_off);
      int          k;
      int          halves;
      int          exp_lat;
      resp_t       r;
      logic [31:0] m;
      logic [20:0] w;
      w = a[22:2];
      ack_delay = A;
      halves = 0;
      if (tmo) begin
         push_tog(1'b0, 2'b11, a, wd, ws);
         r.rdata = 32'hFFFF_FFFF; r.tmo = 1'b1; r.is_read = 1'b1;
         exp_lat = TO + 2;
      end else begin
         if (ws == 4'b0000) begin
            push_tog(1'b0, 2'b11, a, wd, ws);
            push_tog(1'b1, 2'b11, a, wd, ws);
            halves = 2;
            r.rdata = ref_read(w); r.is_read = 1'b1;
         end else begin
            if (ws[1:0] != 2'b00) begin push_tog(1'b0, ws[1:0], a, wd, ws); halves++; end
            if (ws[3:2] != 2'b00) begin push_tog(1'b1, ws[3:2], a, wd, ws); halves++; end
            m = ref_read(w);
            for (int b = 0; b < 4; b++) if (ws[b]) m[b*8 +: 8] = wd[b*8 +: 8];
            ref_mem[w] = m;
            r.rdata = 32'h0; r.is_read = 1'b0;
         end
         r.tmo = 1'b0;
         exp_lat = halves * (A + 1) + 1;
      end
      exp_resp.push_back(r);
      bus.i_mem_valid = 1'b1;
      bus.i_mem_addr = a;
      bus.i_mem_wdata = wd;
      bus.i_mem_wstrb = ws;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (bus.o_mem_ready !== 1'b1 && k < 200);
      if (bus.o_mem_ready !== 1'b1) begin
         n_tests++;
         n_fail++;
         $display("FAIL no_ready: waited %0d cycles, required a ready pulse", k);
         finish_sim();
      end
      if (lat_off >= 0) check("latency", 64'(k), 64'(exp_lat + lat_off));
   endtask

   task automatic idle_bus(int n);
      bus.i_mem_valid = 1'b0;
      bus.i_mem_wstrb = 4'b0000;
      repeat (n) @(negedge clk);
   endtask

   task automatic check_all_zero(string tag);
      check({tag, "_req"}, bus.o_rv_req, 1'b0);
      check({tag, "_ready"}, bus.o_mem_ready, 1'b0);
      check({tag, "_timeout"}, bus.o_timeout, 1'b0);
      check({tag, "_rdata"}, bus.o_mem_rdata, 32'h0);
      check({tag, "_addr"}, bus.o_rv_addr, 23'h0);
      check({tag, "_wdata"}, bus.o_rv_wdata, 32'h0);
      check({tag, "_wstrb"}, bus.o_rv_wstrb, 4'h0);
      check({tag, "_word"}, bus.o_rv_word, 1'b0);
      check({tag, "_ds"}, bus.o_rv_ds, 2'b00);
   endtask

   initial begin
      #200000;
      n_tests++;
      n_fail++;
      $display("FAIL global_timeout: simulation did not complete in time");
      finish_sim();
   end

   initial begin
      logic [22:0] a;
      logic [3:0]  ws;
      int          A;
      bus.i_mem_valid = 1'b0;
      bus.i_mem_addr = 23'h0;
      bus.i_mem_wdata = 32'h0;
      bus.i_mem_wstrb = 4'h0;
      #2 resetn = 1'b0;
      #1 check_all_zero("reset");
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      exp_req = 1'b0;
      chk_tog = 1'b1;
      @(negedge clk);

      // Directed read with known controller contents.
      cmem[{21'(23'h066000 >> 2), 1'b0}] = 16'h1234;
      cmem[{21'(23'h066000 >> 2), 1'b1}] = 16'hABCD;
      ref_mem[21'(23'h066000 >> 2)] = 32'hABCD_1234;
      issue(23'h066000, 32'h0, 4'h0, 4, 1'b0, 0);
      idle_bus(1);

      // Full-word write, then read back.
      issue(23'h000100, 32'hDEAD_BEEF, 4'hF, 3, 1'b0, 0);
      idle_bus(1);
      issue(23'h000100, 32'h0, 4'h0, 2, 1'b0, 0);
      idle_bus(1);

      // Single-half write touching only byte 2, then read back.
      issue(23'h000200, 32'h0077_0000, 4'b0100, 5, 1'b0, 0);
      idle_bus(1);
      issue(23'h000200, 32'h0, 4'h0, 1, 1'b0, 0);
      idle_bus(1);

      // Low-half-only write.
      issue(23'h000204, 32'h0000_5AA5, 4'b0011, 2, 1'b0, 0);
      idle_bus(1);

      // Dead controller: watchdog abort, then a late ack is absorbed.
      dead = 1'b1;
      issue(23'h000300, 32'h0, 4'h0, 4, 1'b1, 0);
      chk_tog = 1'b0;
      idle_bus(3);
      check("resync_after_abort", bus.o_rv_req, bus.i_rv_req_ack);
      late_req_cnt++;
      repeat (3) @(negedge clk);
      check("resync_after_late_ack", bus.o_rv_req, bus.i_rv_req_ack);
      dead = 1'b0;
      exp_req = bus.i_rv_req_ack;
      chk_tog = 1'b1;
      issue(23'h000300, 32'h0, 4'h0, 3, 1'b0, 0);
      idle_bus(1);

      // Back-to-back reads with valid held high.
      issue(23'h000100, 32'h0, 4'h0, 2, 1'b0, 0);
      issue(23'h000200, 32'h0, 4'h0, 2, 1'b0, 1);
      issue(23'h066000, 32'h0, 4'h0, 1, 1'b0, 1);
      idle_bus(1);

      // Reset while waiting on the high half.
      ack_delay = 4;
      push_tog(1'b0, 2'b11, 23'h000400, 32'h0, 4'h0);
      push_tog(1'b1, 2'b11, 23'h000400, 32'h0, 4'h0);
      bus.i_mem_valid = 1'b1;
      bus.i_mem_addr = 23'h000400;
      bus.i_mem_wstrb = 4'h0;
      repeat (7) @(negedge clk);
      chk_tog = 1'b0;
      resetn = 1'b0;
      #1 check_all_zero("midreset");
      bus.i_mem_valid = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      exp_req = 1'b0;
      chk_tog = 1'b1;
      @(negedge clk);
      issue(23'h000400, 32'h0, 4'h0, 3, 1'b0, 0);
      idle_bus(1);

      // Randomized traffic over a small address window.
      for (int i = 0; i < 40; i++) begin
         a  = {18'h0ABC, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
         ws = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
         A  = $urandom_range(1, 6);
         issue(a, $urandom, ws, A, 1'b0, 0);
         while ($urandom_range(0, 2) == 0) begin
            a = {18'h0ABC, 3'($urandom_range(0, 7)), 2'b00};
            issue(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(1, 6), 1'b0, 1);
         end
         idle_bus($urandom_range(1, 2));
      end

      repeat (4) @(negedge clk);
      check("pending_toggles", 64'(exp_tog.size()), 64'd0);
      check("pending_responses", 64'(exp_resp.size()), 64'd0);
      finish_sim();
   end
endmodule

// File: doc/rv_sdram_bridge.md
# rv_sdram_bridge

Initiator-side bridge between the IOSys RISC-V softcore's native 32-bit memory bus and the 16-bit toggle-handshake RV port of the SDRAM controller (`sdram_nes`). The bridge accepts one 32-bit read or strobed write at a time and splits it into up to two 16-bit SDRAM transactions (low half, then high half). It drives the `rv_req` toggle, waits for the matching `rv_req_ack`, and returns the assembled word with a single-cycle `ready` pulse. A watchdog terminates any transaction the controller never acknowledges.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 1023: cycles allowed per 16-bit half before abort; counter width is `$clog2(TIMEOUT_CYCLES+1)`.

Ports:
- `i_clk`  in  1  system clock; one clock domain.
- `i_resetn`  in  1  reset; asynchronous assert, active-low.
- `i_mem_valid`  in  1  CPU request; held high until `o_mem_ready`.
- `i_mem_addr`  in  23  byte address; bits [1:0] ignored.
- `i_mem_wdata`  in  32  write data.
- `i_mem_wstrb`  in  4  byte strobes; 0 = read.
- `o_mem_ready`  out  1  one-cycle completion pulse.
- `o_mem_rdata`  out  32  read data; valid while `o_mem_ready`=1.
- `o_timeout`  out  1  one-cycle pulse, coincident with `o_mem_ready`, on watchdog abort.
- `o_rv_addr`  out  23  latched word address to the controller.
- `o_rv_word`  out  1  0 = low half [15:0], 1 = high half [31:16].
- `o_rv_wdata`  out  32  latched write word.
- `o_rv_ds`  out  2  byte enables for the current half.
- `o_rv_wstrb`  out  4  latched strobes; controller write-enable is `wstrb != 0`.
- `o_rv_req`  out  1  request toggle.
- `i_rv_req_ack`  in  1  acknowledge toggle; the half is complete when it equals `o_rv_req`.
- `i_rv_dout`  in  16  read data for the current half; valid when acknowledged.

## Operation
- States: IDLE, LO, HI, RESP.
- IDLE: if `i_mem_valid` and not `o_mem_ready`, latch addr/wdata/wstrb. Write with `wstrb[1:0]==0`: go directly to HI. Otherwise go to LO. Every entry into LO or HI toggles `o_rv_req` and sets `o_rv_word`/`o_rv_ds` in the same cycle.
- Byte enables:
  - Reads: `o_rv_ds`=2'b11 for both halves.
  - Writes: LO uses `wstrb[1:0]`; HI uses `wstrb[3:2]`.
- LO: wait for `i_rv_req_ack == o_rv_req`, then capture `i_rv_dout` into rdata[15:0].
  - Write with `wstrb[3:2]==0`: go to RESP.
  - Otherwise: go to HI, with a new toggle.
- HI: wait for the acknowledge, capture rdata[31:16], go to RESP.
- RESP: `o_mem_ready`=1 for exactly one cycle, then IDLE. For writes, `o_mem_rdata` holds its previous contents and has no meaning.
- Watchdog: the counter clears on each toggle and increments while waiting. On reaching `TIMEOUT_CYCLES`, go to RESP with rdata=32'hFFFF_FFFF and `o_timeout`=1.
  - `o_rv_req` is not re-toggled after an abort.
  - Before issuing the next request, the bridge resynchronises by setting `o_rv_req` equal to `i_rv_req_ack`. This single-cycle step is taken in IDLE whenever the two differ.
- No pipelining: one outstanding 16-bit request maximum.

## Timing
- Reset values: `o_rv_req`=0, `o_mem_ready`=0, `o_timeout`=0, `o_mem_rdata`=0, `o_rv_addr`=0, `o_rv_wdata`=0, `o_rv_wstrb`=0, `o_rv_word`=0, `o_rv_ds`=0; state IDLE.
- Accept to first toggle: 1 cycle (registered).
- An acknowledge sampled at edge N leads to:
  - next toggle at N+1 (LO→HI), or
  - `o_mem_ready` at N+1 (→RESP).
- Latency with controller ack delay A (A≥1):
  - read or full-word write: 2A+3 cycles;
  - single-half write: A+2 cycles.
- `i_mem_valid` sampled again only in IDLE after RESP, so no request is double-accepted.
- Reset asserted mid-transaction: outputs return to reset values immediately. The controller is reset on the same `i_resetn`, so toggles realign at 0.

## Test plan
- Read 0x066000; controller returns 16'h1234 (low) then 16'hABCD (high), A=4 → two toggles with `o_rv_word` 0 then 1, `o_rv_ds`=11 both times, `o_mem_rdata`=32'hABCD1234, ready at cycle 11.
- Write 32'hDEADBEEF, wstrb=4'hF → two toggles with ds 11/11, `o_rv_wdata`=32'hDEADBEEF, one ready pulse, `o_timeout`=0.
- Write wstrb=4'b0100 → single toggle, `o_rv_word`=1, `o_rv_ds`=2'b01, ready at A+2.
- Controller never acks, TIMEOUT_CYCLES=16 → ready and `o_timeout` pulse at 18 cycles after accept, rdata=32'hFFFF_FFFF. A late ack is then absorbed by the IDLE resync, and the next read completes normally.
- Back-to-back reads with `i_mem_valid` held high → exactly one ready per request, toggles alternate 1,0,1,0.
- Assert `i_resetn`=0 during HI wait → all outputs are 0 on the same edge; a new read after release completes correctly.
